utim64_req_arbiter: RTL

//  Shares the single utim64 register-request port between P_REQ_N bus masters (core, debug unit, ...).

---
 rtl/utim64_pkg.sv | 21 ++
 rtl/utim64_arb_tag_fifo.sv | 66 ++++++
 rtl/utim64_req_arbiter.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/utim64_pkg.sv
// utim64 shared definitions.
// Holds the utim64 register address map endpoints, the request field widths, the default depth
// of the read-tag FIFO, and the type of one registered request toward utim64.
package utim64_pkg;

   localparam int unsigned P_ADDR_W        = 4;
   localparam int unsigned P_DATA_W        = 32;
   localparam int unsigned P_TAG_DEPTH_DEF = 4;

   // Register address map, first and last entries.
   localparam logic [P_ADDR_W-1:0] MCFGR    = 4'h0;
   localparam logic [P_ADDR_W-1:0] ACC3CFRG = 4'hE;

   // One request as held in the issue stage.
   typedef struct packed {
      logic                rw;
      logic [P_ADDR_W-1:0] addr;
      logic [P_DATA_W-1:0] data;
   } iss_t;

endpackage

// File: rtl/utim64_arb_tag_fifo.sv
// In-order tag FIFO for outstanding reads.
// Ports:
//   iCLOCK, inRESET  clock, asynchronous active-low reset
//   iPUSH / iDATA    write a tag (ignored while full)
//   iPOP             drop the head tag (ignored while empty)
//   oDATA            head tag
//   oFULL, oEMPTY    status, registered-state based (no same-cycle bypass)
//   oCOUNT           number of stored tags
module utim64_arb_tag_fifo #(
   parameter int unsigned P_WIDTH   = 1,
   parameter int unsigned P_DEPTH   = 4,
   parameter int unsigned P_DEPTH_N = 2
) (
   input  logic               iCLOCK,
   input  logic               inRESET,
   input  logic               iPUSH,
   input  logic               iPOP,
   input  logic [P_WIDTH-1:0] iDATA,
   output logic [P_WIDTH-1:0] oDATA,
   output logic               oFULL,
   output logic               oEMPTY,
   output logic [P_DEPTH_N:0] oCOUNT
);

   localparam logic [P_DEPTH_N:0] L_FULL_CNT = (P_DEPTH_N + 1)'(P_DEPTH);

   logic [P_WIDTH-1:0]   b_mem [P_DEPTH];
   logic [P_DEPTH_N-1:0] b_wr_ptr;
   logic [P_DEPTH_N-1:0] b_rd_ptr;
   logic [P_DEPTH_N:0]   b_count;
   logic                 do_push;
   logic                 do_pop;

   assign oFULL   = (b_count == L_FULL_CNT);
   assign oEMPTY  = (b_count == '0);
   assign oCOUNT  = b_count;
   assign oDATA   = b_mem[b_rd_ptr];
   assign do_push = iPUSH && !oFULL;
   assign do_pop  = iPOP && !oEMPTY;

   always_ff @(posedge iCLOCK or negedge inRESET) begin
      if (!inRESET) begin
         b_wr_ptr <= '0;
         b_rd_ptr <= '0;
         b_count  <= '0;
         for (int i = 0; i < int'(P_DEPTH); i++) begin
            b_mem[i] <= '0;
         end
      end else begin
         if (do_push) begin
            b_mem[b_wr_ptr] <= iDATA;
            b_wr_ptr        <= b_wr_ptr + 1'b1;
         end
         if (do_pop) begin
            b_rd_ptr <= b_rd_ptr + 1'b1;
         end
         // Push and pop together leave the count unchanged.
         if (do_push && !do_pop) begin
            b_count <= b_count + 1'b1;
         end else if (do_pop && !do_push) begin
            b_count <= b_count - 1'b1;
         end
      end
   end

endmodule

// File: rtl/utim64_req_arbiter.sv
// Shares the single utim64 register-request port between P_REQ_N bus masters.
// Round-robin grant into one registered issue stage; read responses return in order and are
// routed back to the issuing master through an in-order tag FIFO.
// Ports:
//   iCLOCK, inRESET      clock, asynchronous active-low reset
//   iREQ_VALID/RW/ADDR/DATA  per-master requests (master k at slice k)
//   oREQ_BUSY            per-master busy; accepted when VALID=1 and BUSY=0
//   oRSP_VALID/DATA      one-cycle read-response strobe per master, shared data
//   oTIM_REQ_*           registered request toward utim64, iTIM_REQ_BUSY stalls it
//   iTIM_RSP_VALID/DATA  in-order read responses from utim64
//   oERR                 sticky: response arrived with no read outstanding
module utim64_req_arbiter
   import utim64_pkg::*;
#(
   parameter int unsigned P_REQ_N       = 2,
   parameter int unsigned P_REQ_L       = 1,
   parameter int unsigned P_TAG_DEPTH   = P_TAG_DEPTH_DEF,
   parameter int unsigned P_TAG_DEPTH_N = 2
) (
   input  logic                        iCLOCK,
   input  logic                        inRESET,
   input  logic [P_REQ_N-1:0]          iREQ_VALID,
   output logic [P_REQ_N-1:0]          oREQ_BUSY,
   input  logic [P_REQ_N-1:0]          iREQ_RW,
   input  logic [P_ADDR_W*P_REQ_N-1:0] iREQ_ADDR,
   input  logic [P_DATA_W*P_REQ_N-1:0] iREQ_DATA,
   output logic [P_REQ_N-1:0]          oRSP_VALID,
   output logic [P_DATA_W-1:0]         oRSP_DATA,
   output logic                        oTIM_REQ_VALID,
   input  logic                        iTIM_REQ_BUSY,
   output logic                        oTIM_REQ_RW,
   output logic [P_ADDR_W-1:0]         oTIM_REQ_ADDR,
   output logic [P_DATA_W-1:0]         oTIM_REQ_DATA,
   input  logic                        iTIM_RSP_VALID,
   input  logic [P_DATA_W-1:0]         iTIM_RSP_DATA,
   output logic                        oERR
);

   localparam logic [P_TAG_DEPTH_N:0] L_FULL_CNT = (P_TAG_DEPTH_N + 1)'(P_TAG_DEPTH);

   iss_t                   b_iss;
   logic                   b_iss_valid;
   logic [P_REQ_L-1:0]     b_rr_ptr;
   logic [P_REQ_N-1:0]     b_rsp_valid;
   logic [P_DATA_W-1:0]    b_rsp_data;
   logic                   b_err;

   logic                   slot_free;
   logic [P_REQ_N-1:0]     eligible;
   logic [P_REQ_N-1:0]     grant;
   logic                   grant_any;
   logic [P_REQ_L-1:0]     grant_idx;
   iss_t                   grant_req;

   logic                   tag_push;
   logic                   tag_pop;
   logic                   tag_full;
   logic                   tag_empty;
   logic [P_REQ_L-1:0]     tag_head;
   logic [P_TAG_DEPTH_N:0] tag_count;
   logic [P_REQ_N-1:0]     rsp_onehot;

   // A stalled stage frees up in the same cycle utim64 takes it.
   assign slot_free = !b_iss_valid || !iTIM_REQ_BUSY;
   // Writes carry no tag, so only reads are held back by a full tag FIFO.
   assign eligible  = iREQ_VALID & {P_REQ_N{slot_free}} & (iREQ_RW | {P_REQ_N{!tag_full}});

   // Round-robin: first eligible master above the last one granted.
   always_comb begin
      int k;
      grant     = '0;
      grant_any = 1'b0;
      grant_idx = '0;
      grant_req = '0;
      k         = 0;
      for (int i = 1; i <= int'(P_REQ_N); i++) begin
         k = (int'(b_rr_ptr) + i) % int'(P_REQ_N);
         if (!grant_any && eligible[k]) begin
            grant_any      = 1'b1;
            grant[k]       = 1'b1;
            grant_idx      = P_REQ_L'(k);
            grant_req.rw   = iREQ_RW[k];
            grant_req.addr = iREQ_ADDR[k*P_ADDR_W +: P_ADDR_W];
            grant_req.data = iREQ_DATA[k*P_DATA_W +: P_DATA_W];
         end
      end
   end

   assign oREQ_BUSY = ~grant;
   assign tag_push  = grant_any && !grant_req.rw;
   assign tag_pop   = iTIM_RSP_VALID && !tag_empty;

   always_ff @(posedge iCLOCK or negedge inRESET) begin
      if (!inRESET) begin
         b_iss_valid <= 1'b0;
         b_iss       <= '0;
         b_rr_ptr    <= '0;
      end else if (grant_any) begin
         b_iss_valid <= 1'b1;
         b_iss       <= grant_req;
         b_rr_ptr    <= grant_idx;
      end else if (slot_free) begin
         b_iss_valid <= 1'b0;
      end
   end

   utim64_arb_tag_fifo #(
      .P_WIDTH   (P_REQ_L),
      .P_DEPTH   (P_TAG_DEPTH),
      .P_DEPTH_N (P_TAG_DEPTH_N)
   ) u_tag_fifo (
      .iCLOCK (iCLOCK),
      .inRESET(inRESET),
      .iPUSH  (tag_push),
      .iPOP   (tag_pop),
      .iDATA  (grant_idx),
      .oDATA  (tag_head),
      .oFULL  (tag_full),
      .oEMPTY (tag_empty),
      .oCOUNT (tag_count)
   );

   // The status flags and the count come from the same state; they must never disagree.
   always_comb begin
      if (inRESET) begin
         assert (tag_full == (tag_count == L_FULL_CNT) && tag_empty == (tag_count == '0));
      end
   end

   always_comb begin
      rsp_onehot           = '0;
      rsp_onehot[tag_head] = 1'b1;
   end

   always_ff @(posedge iCLOCK or negedge inRESET) begin
      if (!inRESET) begin
         b_rsp_valid <= '0;
         b_rsp_data  <= '0;
         b_err       <= 1'b0;
      end else begin
         b_rsp_valid <= '0;
         if (tag_pop) begin
            b_rsp_valid <= rsp_onehot;
            b_rsp_data  <= iTIM_RSP_DATA;
         end
         // Stray response: nobody to route it to, drop it and flag.
         if (iTIM_RSP_VALID && tag_empty) begin
            b_err <= 1'b1;
         end
      end
   end

   assign oTIM_REQ_VALID = b_iss_valid;
   assign oTIM_REQ_RW    = b_iss.rw;
   assign oTIM_REQ_ADDR  = b_iss.addr;
   assign oTIM_REQ_DATA  = b_iss.data;
   assign oRSP_VALID     = b_rsp_valid;
   assign oRSP_DATA      = b_rsp_data;
   assign oERR           = b_err;

endmodule
